// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline boundary register with valid/ready handshake, 2-entry skid buffer and flush.
// Define EX_MEM_PERF_CNT_EN to add saturating stall/bubble/flush performance counters.
module ex_mem_pipe_reg #(
    parameter int                 DATA_W     = 32,
    parameter int                 REG_ADDR_W = 5,
    parameter int                 CTRL_W     = 4,
    parameter logic [CTRL_W-1:0]  GATE_MASK  = 4'b0111,
    parameter int                 CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_alu,
    input  logic [DATA_W-1:0]     in_data,
    input  logic [REG_ADDR_W-1:0] in_dest,
    input  logic [CTRL_W-1:0]     in_ctrl,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_alu,
    output logic [DATA_W-1:0]     out_data,
    output logic [REG_ADDR_W-1:0] out_dest,
`ifdef EX_MEM_PERF_CNT_EN
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      bubble_cnt,
    output logic [CNT_W-1:0]      flush_cnt,
`endif
    output logic [CTRL_W-1:0]     out_ctrl
);

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [DATA_W-1:0]     data;
        logic [REG_ADDR_W-1:0] dest;
        logic [CTRL_W-1:0]     ctrl;
    } entry_t;

    entry_t main_q, skid_q, in_entry;
    logic   main_v, skid_v;
    logic   accept, main_free;

    assign in_entry  = '{alu: in_alu, data: in_data, dest: in_dest, ctrl: in_ctrl};
    // in_ready depends only on registered state, so a MEM stall never ripples back combinationally.
    assign in_ready  = !skid_v;
    assign accept    = in_valid && in_ready && !flush;
    assign main_free = !main_v || out_ready;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // NOTE: payload registers are reset too, so outputs read 0 during reset rather than X.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (flush) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
        end else if (main_free) begin
            // skid_v=1 implies in_ready=0, so the skid entry and a new accept never collide here.
            if (skid_v) begin
                main_q <= skid_q;
                main_v <= 1'b1;
                skid_v <= 1'b0;
            end else if (accept) begin
                main_q <= in_entry;
                main_v <= 1'b1;
            end else begin
                main_v <= 1'b0;
            end
        end else if (accept) begin
            skid_q <= in_entry;
            skid_v <= 1'b1;
        end
    end

    assign out_valid = main_v;
    assign out_alu   = main_q.alu;
    assign out_data  = main_q.data;
    assign out_dest  = main_q.dest;
    // Masked control bits read as 0 in bubbles so a stale MemRd/MemWr/WrReg never reaches MEM.
    assign out_ctrl  = main_q.ctrl & (main_v ? {CTRL_W{1'b1}} : ~GATE_MASK);

`ifdef EX_MEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (main_v && !out_ready && stall_cnt != {CNT_W{1'b1}})
                stall_cnt <= stall_cnt + 1'b1;
            if (!main_v && bubble_cnt != {CNT_W{1'b1}})
                bubble_cnt <= bubble_cnt + 1'b1;
            if (flush && (main_v || skid_v) && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Directed self-checking bench for ex_mem_pipe_reg: reset, skid stall, streaming, flush, gating.
// Counter checks are compiled in only when EX_MEM_PERF_CNT_EN is defined.
module tb_ex_mem_pipe_reg;

    localparam int DATA_W = 32;
    localparam int RA_W   = 5;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_alu;
    logic [DATA_W-1:0] in_data;
    logic [RA_W-1:0]   in_dest;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_alu;
    logic [DATA_W-1:0] out_data;
    logic [RA_W-1:0]   out_dest;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef EX_MEM_PERF_CNT_EN
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    ex_mem_pipe_reg #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_alu    (in_alu),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_alu   (out_alu),
        .out_data  (out_data),
        .out_dest  (out_dest),
`ifdef EX_MEM_PERF_CNT_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
        .flush_cnt (flush_cnt),
`endif
        .out_ctrl  (out_ctrl)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] alu, input logic [RA_W-1:0] dest,
                         input logic [CTRL_W-1:0] ctrl);
        in_valid = v;
        in_alu   = alu;
        in_data  = alu ^ 32'hA5A5_0000;
        in_dest  = dest;
        in_ctrl  = ctrl;
    endtask

    initial begin
        rst = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 32'h55, 5'd3, 4'b1111);
        tick();
        tick();
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_ctrl",  {60'd0, out_ctrl}, 64'd0);
        check("rst_in_ready",  {63'd0, in_ready}, 64'd1);
        check("rst_out_alu",   {32'd0, out_alu}, 64'd0);

        // First entry after reset: one-cycle latency
        drive(1'b1, 32'h0000_1234, 5'd5, 4'b0100);
        rst = 1'b1;
        tick();
        check("first_valid", {63'd0, out_valid}, 64'd1);
        check("first_alu",   {32'd0, out_alu}, 64'h1234);
        check("first_data",  {32'd0, out_data}, 64'hA5A5_1234);
        check("first_dest",  {59'd0, out_dest}, 64'd5);
        check("first_ctrl",  {60'd0, out_ctrl}, 64'b0100);
        drive(1'b0, 32'h0, 5'd0, 4'b0000);
        tick();
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        check("drain_ctrl",  {60'd0, out_ctrl}, 64'b0000);
        check("drain_alu_hold", {32'd0, out_alu}, 64'h1234);

        // Stall with skid: A then B, C offered while full must be ignored
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 5'd1, 4'b0001);
        tick();
        check("stall_a_alu", {32'd0, out_alu}, 64'd1);
        check("stall_a_rdy", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'd2, 5'd2, 4'b0010);
        tick();
        check("stall_b_rdy", {63'd0, in_ready}, 64'd0);
        check("stall_b_alu", {32'd0, out_alu}, 64'd1);
        drive(1'b1, 32'd3, 5'd3, 4'b0001);
        tick();
        check("stall_full_rdy", {63'd0, in_ready}, 64'd0);
        check("stall_full_alu", {32'd0, out_alu}, 64'd1);
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        out_ready = 1'b1;
        tick();
        check("skid_b_valid", {63'd0, out_valid}, 64'd1);
        check("skid_b_alu",   {32'd0, out_alu}, 64'd2);
        check("skid_b_dest",  {59'd0, out_dest}, 64'd2);
        check("skid_b_rdy",   {63'd0, in_ready}, 64'd1);
        tick();
        check("skid_empty", {63'd0, out_valid}, 64'd0);

        // Back-to-back streaming
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'(10 + i), 5'(i), 4'b0100);
            tick();
            check("b2b_alu",   {32'd0, out_alu}, 64'(10 + i));
            check("b2b_valid", {63'd0, out_valid}, 64'd1);
            check("b2b_rdy",   {63'd0, in_ready}, 64'd1);
        end
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        tick();
        check("b2b_end", {63'd0, out_valid}, 64'd0);

        // Flush with both entries held
        out_ready = 1'b0;
        drive(1'b1, 32'd20, 5'd4, 4'b0111);
        tick();
        drive(1'b1, 32'd21, 5'd6, 4'b0110);
        tick();
        check("fl_full_rdy", {63'd0, in_ready}, 64'd0);
        flush = 1'b1;
        drive(1'b1, 32'd7, 5'd7, 4'b0111);
        #1;
        check("fl_rdy_prev", {63'd0, in_ready}, 64'd0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_rdy",   {63'd0, in_ready}, 64'd1);
        check("fl_ctrl",  {60'd0, out_ctrl}, 64'b0000);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_no_b",  {63'd0, out_valid}, 64'd0);
        check("fl_alu_hold", {32'd0, out_alu}, 64'd20);

        // Flush on an empty stage discards the offered entry
        flush = 1'b1;
        drive(1'b1, 32'd7, 5'd7, 4'b0111);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        check("fl_empty_valid", {63'd0, out_valid}, 64'd0);
        check("fl_empty_alu",   {32'd0, out_alu}, 64'd20);

        // Gating: full control in main, then bubble
        out_ready = 1'b0;
        drive(1'b1, 32'd30, 5'd9, 4'b1111);
        tick();
        check("gate_full", {60'd0, out_ctrl}, 64'b1111);
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        out_ready = 1'b1;
        tick();
        check("gate_bubble", {60'd0, out_ctrl}, 64'b1000);
        check("gate_alu",    {32'd0, out_alu}, 64'd30);

        // Asynchronous reset mid-operation
        out_ready = 1'b0;
        drive(1'b1, 32'd40, 5'd1, 4'b0100);
        tick();
        drive(1'b1, 32'd41, 5'd2, 4'b0100);
        tick();
        #2;
        rst = 1'b0;
        #1;
        check("amr_valid", {63'd0, out_valid}, 64'd0);
        check("amr_rdy",   {63'd0, in_ready}, 64'd1);
        check("amr_alu",   {32'd0, out_alu}, 64'd0);
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        tick();
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        check("amr_idle", {63'd0, out_valid}, 64'd0);

`ifdef EX_MEM_PERF_CNT_EN
        out_ready = 1'b0;
        drive(1'b1, 32'd50, 5'd1, 4'b0100);
        tick();
        drive(1'b0, 32'd0, 5'd0, 4'b0000);
        for (int i = 0; i < 20; i++) tick();
        check("cnt_stall_sat", {60'd0, stall_cnt}, 64'd15);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("cnt_flush", {60'd0, flush_cnt}, 64'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
- Parametrised EX→MEM pipeline boundary register for the pipelined core.
- Carries ALU result, store data, destination register and a generic control vector.
- Adds a valid/ready handshake with a 2-entry skid buffer, so a MEM-side stall never drops or duplicates an instruction.
- Adds a synchronous flush that turns in-flight entries into bubbles.

Parameters:
- DATA_W, 32, width of the ALU result and store-data fields
- REG_ADDR_W, 5, width of the destination register index
- CTRL_W, 4, control vector width; bit0 MemRd, bit1 MemWr, bit2 WrReg, bit3 DataSrc
- GATE_MASK, 4'b0111, CTRL_W-bit mask; a set bit means that control output is forced to 0 while out_valid=0
- CNT_W, 16, performance counter width (only used with the optional feature)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-low (0 = reset)
- flush  in  1  synchronous; invalidates both held entries
- in_valid  in  1  EX stage presents an entry
- in_ready  out  1  stage can accept an entry
- in_alu  in  DATA_W  ALU result
- in_data  in  DATA_W  store data
- in_dest  in  REG_ADDR_W  destination register
- in_ctrl  in  CTRL_W  control vector
- out_valid  out  1  MEM stage entry valid
- out_ready  in  1  MEM stage accepts the entry
- out_alu  out  DATA_W  registered ALU result
- out_data  out  DATA_W  registered store data
- out_dest  out  REG_ADDR_W  registered destination register
- out_ctrl  out  CTRL_W  registered control vector, gated per GATE_MASK

Behaviour:
- State:
  - main register plus main_v
  - skid register plus skid_v
- Reset (rst=0, asynchronous):
  - main_v=0, skid_v=0, all payload registers 0.
  - Outputs during reset: out_valid=0, out_* = 0, in_ready=1.
- Ready and transfer rules:
  - in_ready = !skid_v. It is a registered term only and has no combinational path from out_ready or flush.
  - Accept occurs when in_valid & in_ready & !flush.
  - Emit occurs when main_v & out_ready.
- Per-cycle update (flush=0):
  - Main free (main_v=0) or emitting: main <= skid if skid_v, else the accepted entry; main_v updates accordingly.
  - Main free/emitting, skid_v=1 and accept in the same cycle: impossible, because in_ready=0.
  - Main held (main_v=1 & !out_ready) and accept: skid <= entry, skid_v=1.
  - Skid drains into main on the first emit cycle; skid_v clears.
- Latency and throughput:
  - Unstalled latency is 1 cycle.
  - Throughput is 1 entry/cycle while out_ready=1.
- Ordering:
  - Strict FIFO order, at most 2 entries held.
  - No entry is lost or duplicated.
- Flush (synchronous):
  - Next edge: main_v=0, skid_v=0.
  - An entry offered in the same cycle is discarded, and in_ready is still reported as in the previous state.
  - Flush overrides emit/accept.
  - Payload registers need not be cleared.
- Output gating:
  - out_alu, out_data and out_dest hold their last registered value while out_valid=0.
  - out_ctrl[i] = main_ctrl[i] & (main_v | !GATE_MASK[i]). Bubbles therefore never assert MemRd, MemWr or WrReg.
- Reset mid-operation:
  - All entries drop immediately, asynchronously.
  - After rst deasserts, the first edge behaves like an idle stage.
- Width rules:
  - Pure pass-through, no arithmetic on payload.
  - GATE_MASK wider or narrower than CTRL_W is illegal.

Optional Feature:
- Macro EX_MEM_PERF_CNT_EN.
- When defined, adds outputs stall_cnt, bubble_cnt and flush_cnt, each CNT_W bits:
  - stall_cnt increments on main_v & !out_ready.
  - bubble_cnt increments on !main_v.
  - flush_cnt increments on flush & (main_v | skid_v).
  - All counters saturate at all-ones and reset to 0 on rst.
- When undefined, these ports and their logic do not exist, and the block behaves identically otherwise.

Test Plan:
- Reset: rst=0 with in_valid=1 → out_valid=0, out_ctrl=0, in_ready=1. After release, enter alu=0x0000_1234, dest=5, ctrl=4'b0100 → one cycle later out_valid=1, out_alu=0x1234, out_ctrl=4'b0100.
- Stall with skid: out_ready=0 while sending A (alu=1) then B (alu=2) → in_ready=0 after B. Raise out_ready → outputs A then B on consecutive cycles, with no loss.
- Back-to-back: out_ready=1, stream alu=10,11,12 → out_alu 10,11,12 on three consecutive cycles, with in_ready held at 1.
- Flush: two entries held (stall), flush=1 for one cycle with in_valid=1 (alu=7) → next cycle out_valid=0, in_ready=1, out_ctrl[2:0]=0, and alu=7 never appears.
- Gating: main holds ctrl=4'b1111, then bubble → out_ctrl=4'b1000 with the default GATE_MASK.
- With EX_MEM_PERF_CNT_EN and CNT_W=4: hold a stall for 20 cycles → stall_cnt=15 (saturated).
